// File: rtl/kogge_stone_adder_if.sv
// Operand/result bundle for the Kogge-Stone adder.
// The master side drives the operands and carry-in; the slave side (the adder)
// returns the combinational sum and its registered copy.
interface kogge_stone_adder_if #(
  parameter int N = 64
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N:0]   S;
  logic [N:0]   S_reg;

  modport master (
    output A,
    output B,
    output Cin,
    input  S,
    input  S_reg
  );

  modport slave (
    input  A,
    input  B,
    input  Cin,
    output S,
    output S_reg
  );
endinterface

// File: rtl/kogge_stone_adder.sv
// N-bit Kogge-Stone parallel-prefix adder producing the full (N+1)-bit value
// A + B + Cin. The sum is purely combinational. A registered copy is kept for
// pipelined users and is cleared asynchronously by rst.
//
// The carry-in is treated as an extra prefix position below bit 0, with
// G = Cin and P = 0. Position j of the prefix vectors therefore holds operand
// bit j-1. After the last stage, the group generate at position j is the
// carry into operand bit j.
module kogge_stone_adder #(
  parameter int N = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  kogge_stone_adder_if.slave       bus
);

  localparam int M = N + 1;          // prefix positions, including the Cin slot
  localparam int L = $clog2(M);      // prefix stages; M >= 2, so L >= 1

  logic [N-1:0] gbit;
  logic [N-1:0] pbit;
  logic [N:0]   carry;
  logic [N:0]   sum;

  assign gbit = bus.A & bus.B;
  assign pbit = bus.A ^ bus.B;

  for (genvar k = 0; k <= L; k++) begin : lvl
    logic [M-1:0] g;
    logic [M-1:0] p;

    if (k == 0) begin : init
      assign g = {gbit, bus.Cin};
      assign p = {pbit, 1'b0};
    end else begin : node
      localparam int D = 1 << (k - 1);

      for (genvar j = 0; j < M; j++) begin : col
        if (j >= D) begin : op
          assign g[j] = lvl[k-1].g[j] | (lvl[k-1].p[j] & lvl[k-1].g[j-D]);
          assign p[j] = lvl[k-1].p[j] & lvl[k-1].p[j-D];
        end else begin : buf_pass
          assign g[j] = lvl[k-1].g[j];
          assign p[j] = lvl[k-1].p[j];
        end
      end
    end
  end

  // The group propagate leaving the last stage has no consumer.
  logic unused_final_p;
  assign unused_final_p = &{1'b0, lvl[L].p};

  assign carry = lvl[L].g;
  assign sum   = {carry[N], pbit ^ carry[N-1:0]};
  assign bus.S = sum;

  // Output register: capture the sum on every edge, clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.S_reg <= '0;
    end else begin
      bus.S_reg <= sum;
    end
  end

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Bench for kogge_stone_adder: the N=64 instance gets directed corner vectors,
// random vectors and reset checks. The instances with N = 1, 7, 8 and 33 get
// the corner vectors.
module tb_kogge_stone_adder;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  kogge_stone_adder_if #(.N(64)) b64 ();
  kogge_stone_adder_if #(.N(1))  b1 ();
  kogge_stone_adder_if #(.N(7))  b7 ();
  kogge_stone_adder_if #(.N(8))  b8 ();
  kogge_stone_adder_if #(.N(33)) b33 ();

  kogge_stone_adder #(.N(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  kogge_stone_adder #(.N(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
  kogge_stone_adder #(.N(7))  dut7  (.clk(clk), .rst(rst), .bus(b7));
  kogge_stone_adder #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  kogge_stone_adder #(.N(33)) dut33 (.clk(clk), .rst(rst), .bus(b33));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive64(input logic [63:0] a, input logic [63:0] b, input logic c);
    @(negedge clk);
    b64.A   = a;
    b64.B   = b;
    b64.Cin = c;
  endtask

  task automatic test_reset;
    b64.A = 64'd5; b64.B = 64'd3; b64.Cin = 1'b1;
    #1;
    nvec++;
    if (b64.S_reg !== 65'h0) begin nerr++; $display("FAIL reset_sreg: got %h expected %h", b64.S_reg, 65'h0); end
    nvec++;
    if (b64.S !== 65'h9) begin nerr++; $display("FAIL reset_s: got %h expected %h", b64.S, 65'h9); end
    @(posedge clk); #1;
    nvec++;
    if (b64.S_reg !== 65'h0) begin nerr++; $display("FAIL reset_hold: got %h expected %h", b64.S_reg, 65'h0); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (b64.S_reg !== 65'h0) begin nerr++; $display("FAIL reset_release: got %h expected %h", b64.S_reg, 65'h0); end
    @(posedge clk); #1;
    nvec++;
    if (b64.S_reg !== 65'h9) begin nerr++; $display("FAIL reset_first_capture: got %h expected %h", b64.S_reg, 65'h9); end
  endtask

  task automatic test_corners;
    logic [63:0] av [4];
    logic [63:0] bv [4];
    logic        cv [4];
    logic [64:0] ev [4];
    av[0] = 64'h0;                   bv[0] = 64'h0;                   cv[0] = 1'b0; ev[0] = 65'h0;
    av[1] = 64'hFFFF_FFFF_FFFF_FFFF; bv[1] = 64'h0;                   cv[1] = 1'b1; ev[1] = 65'h1_0000_0000_0000_0000;
    av[2] = 64'hFFFF_FFFF_FFFF_FFFF; bv[2] = 64'hFFFF_FFFF_FFFF_FFFF; cv[2] = 1'b1; ev[2] = 65'h1_FFFF_FFFF_FFFF_FFFF;
    av[3] = 64'hAAAA_AAAA_AAAA_AAAA; bv[3] = 64'h5555_5555_5555_5555; cv[3] = 1'b0; ev[3] = 65'h0_FFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      drive64(av[i], bv[i], cv[i]);
      #1;
      nvec++;
      if (b64.S !== ev[i]) begin nerr++; $display("FAIL corner%0d_s: got %h expected %h", i, b64.S, ev[i]); end
      @(posedge clk); #1;
      nvec++;
      if (b64.S_reg !== ev[i]) begin nerr++; $display("FAIL corner%0d_sreg: got %h expected %h", i, b64.S_reg, ev[i]); end
    end
  endtask

  task automatic test_random;
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [64:0] e;
    logic [64:0] prev;
    prev = b64.S_reg;
    for (int i = 0; i < 10000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      e = {1'b0, a} + {1'b0, b} + {64'h0, c};
      drive64(a, b, c);
      #1;
      nvec++;
      if (b64.S !== e) begin nerr++; $display("FAIL rand%0d_s: a=%h b=%h c=%0d got %h expected %h", i, a, b, c, b64.S, e); end
      nvec++;
      if (b64.S_reg !== prev) begin nerr++; $display("FAIL rand%0d_sreg_prev: got %h expected %h", i, b64.S_reg, prev); end
      @(posedge clk); #1;
      nvec++;
      if (b64.S_reg !== e) begin nerr++; $display("FAIL rand%0d_sreg: got %h expected %h", i, b64.S_reg, e); end
      prev = e;
    end
  endtask

  task automatic test_mid_reset;
    drive64(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
    @(posedge clk); #1;
    nvec++;
    if (b64.S_reg !== 65'h1_1111_1111_1111_1101) begin nerr++; $display("FAIL mid_pre: got %h expected %h", b64.S_reg, 65'h1_1111_1111_1111_1101); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (b64.S_reg !== 65'h0) begin nerr++; $display("FAIL mid_clear: got %h expected %h", b64.S_reg, 65'h0); end
    nvec++;
    if (b64.S !== 65'h1_1111_1111_1111_1101) begin nerr++; $display("FAIL mid_s: got %h expected %h", b64.S, 65'h1_1111_1111_1111_1101); end
    @(posedge clk); #1;
    nvec++;
    if (b64.S_reg !== 65'h0) begin nerr++; $display("FAIL mid_hold: got %h expected %h", b64.S_reg, 65'h0); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (b64.S_reg !== 65'h1_1111_1111_1111_1101) begin nerr++; $display("FAIL mid_recover: got %h expected %h", b64.S_reg, 65'h1_1111_1111_1111_1101); end
  endtask

  task automatic test_width_sweep;
    logic [0:0]  a1, bb1;
    logic [1:0]  e1;
    logic [6:0]  a7, bb7;
    logic [7:0]  e7;
    logic [7:0]  a8, bb8;
    logic [8:0]  e8;
    logic [32:0] a33, bb33;
    logic [33:0] e33;
    logic        c;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          c = 1'b0;
          a1 = 1'b0;   bb1 = 1'b0;   e1 = 2'b00;
          a7 = 7'h00;  bb7 = 7'h00;  e7 = 8'h00;
          a8 = 8'h00;  bb8 = 8'h00;  e8 = 9'h000;
          a33 = 33'h0; bb33 = 33'h0; e33 = 34'h0;
        end
        1: begin
          c = 1'b1;
          a1 = 1'b1;   bb1 = 1'b0;   e1 = 2'b10;
          a7 = 7'h7F;  bb7 = 7'h00;  e7 = 8'h80;
          a8 = 8'hFF;  bb8 = 8'h00;  e8 = 9'h100;
          a33 = 33'h1_FFFF_FFFF; bb33 = 33'h0; e33 = 34'h2_0000_0000;
        end
        2: begin
          c = 1'b1;
          a1 = 1'b1;   bb1 = 1'b1;   e1 = 2'b11;
          a7 = 7'h7F;  bb7 = 7'h7F;  e7 = 8'hFF;
          a8 = 8'hFF;  bb8 = 8'hFF;  e8 = 9'h1FF;
          a33 = 33'h1_FFFF_FFFF; bb33 = 33'h1_FFFF_FFFF; e33 = 34'h3_FFFF_FFFF;
        end
        default: begin
          c = 1'b0;
          a1 = 1'b0;   bb1 = 1'b1;   e1 = 2'b01;
          a7 = 7'h2A;  bb7 = 7'h55;  e7 = 8'h7F;
          a8 = 8'hAA;  bb8 = 8'h55;  e8 = 9'h0FF;
          a33 = 33'h0_AAAA_AAAA; bb33 = 33'h1_5555_5555; e33 = 34'h1_FFFF_FFFF;
        end
      endcase
      @(negedge clk);
      b1.A = a1;   b1.B = bb1;   b1.Cin = c;
      b7.A = a7;   b7.B = bb7;   b7.Cin = c;
      b8.A = a8;   b8.B = bb8;   b8.Cin = c;
      b33.A = a33; b33.B = bb33; b33.Cin = c;
      #1;
      nvec++;
      if (b1.S !== e1) begin nerr++; $display("FAIL n1_case%0d_s: got %h expected %h", i, b1.S, e1); end
      nvec++;
      if (b7.S !== e7) begin nerr++; $display("FAIL n7_case%0d_s: got %h expected %h", i, b7.S, e7); end
      nvec++;
      if (b8.S !== e8) begin nerr++; $display("FAIL n8_case%0d_s: got %h expected %h", i, b8.S, e8); end
      nvec++;
      if (b33.S !== e33) begin nerr++; $display("FAIL n33_case%0d_s: got %h expected %h", i, b33.S, e33); end
      @(posedge clk); #1;
      nvec++;
      if (b1.S_reg !== e1) begin nerr++; $display("FAIL n1_case%0d_sreg: got %h expected %h", i, b1.S_reg, e1); end
      nvec++;
      if (b7.S_reg !== e7) begin nerr++; $display("FAIL n7_case%0d_sreg: got %h expected %h", i, b7.S_reg, e7); end
      nvec++;
      if (b8.S_reg !== e8) begin nerr++; $display("FAIL n8_case%0d_sreg: got %h expected %h", i, b8.S_reg, e8); end
      nvec++;
      if (b33.S_reg !== e33) begin nerr++; $display("FAIL n33_case%0d_sreg: got %h expected %h", i, b33.S_reg, e33); end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    b64.A = '0; b64.B = '0; b64.Cin = 1'b0;
    b1.A  = '0; b1.B  = '0; b1.Cin  = 1'b0;
    b7.A  = '0; b7.B  = '0; b7.Cin  = 1'b0;
    b8.A  = '0; b8.B  = '0; b8.Cin  = 1'b0;
    b33.A = '0; b33.B = '0; b33.Cin = 1'b0;
    test_reset();
    test_corners();
    test_random();
    test_mid_reset();
    test_width_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
